// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: pipeline request/response ports and the RAM byte bus.
// slave is the controller side; master is the pipeline and RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [31:0]           if_data_o;
  logic [1:0]            if_status;
  logic [2:0]            rw_mem;
  logic [ADDR_WIDTH-1:0] addr_to_mem;
  logic [31:0]           data_to_mem;
  logic [3:0]            quantity;
  logic [31:0]           data_from_mem;
  logic [1:0]            mem_status;
  logic [7:0]            ram_din;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [7:0]            ram_dout;
  logic                  ram_wr;

  modport slave (
    input  if_req, if_addr,
    input  rw_mem, addr_to_mem,
    input  data_to_mem, quantity,
    input  ram_din,
    output if_data_o, if_status,
    output data_from_mem, mem_status,
    output ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr,
    output rw_mem, addr_to_mem,
    output data_to_mem, quantity,
    output ram_din,
    input  if_data_o, if_status,
    input  data_from_mem, mem_status,
    input  ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial IF/MEM arbiter for the 8-bit unified RAM.
// Define MEMCTRL_FETCH_BUF_EN for a one-entry fetch buffer.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [2:0] RW_RD   = 3'b001;
  localparam logic [2:0] RW_WR   = 3'b010;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  state_t                state_q;
  logic                  owner_if_q;
  logic [2:0]            cnt_q;
  logic [2:0]            n_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           acc_q;
  logic [31:0]           acc_fill;
  logic [31:0]           if_data_q;
  logic [31:0]           mem_data_q;
  logic                  mem_rd;
  logic                  mem_wr;
  logic                  wr_c;
  logic                  drive_a;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [7:0]            wbyte;
  logic [1:0]            st;
`ifdef MEMCTRL_FETCH_BUF_EN
  logic                  fb_valid_q;
  logic [ADDR_WIDTH-1:0] fb_tag_q;
  logic [31:0]           fb_word_q;
  logic                  fb_hit;
`endif

  function automatic logic [2:0] n_of(
    input logic [3:0] q
  );
    case (q)
      4'd1:    return 3'd1;
      4'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign mem_rd = bus.rw_mem == RW_RD;
  assign mem_wr = bus.rw_mem == RW_WR;
  assign addr_c = base_q + ADDR_WIDTH'(cnt_q);

  // cnt=k drops the byte addressed at k-1 into lane k-1
  always_comb begin
    acc_fill = acc_q;
    case (cnt_q)
      3'd1:    acc_fill[7:0]   = bus.ram_din;
      3'd2:    acc_fill[15:8]  = bus.ram_din;
      3'd3:    acc_fill[23:16] = bus.ram_din;
      3'd4:    acc_fill[31:24] = bus.ram_din;
      default: ;
    endcase
  end

  always_comb begin
    wbyte = 8'h00;
    case (cnt_q[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  always_comb begin
    st = ST_IDLE;
    unique case (1'b1)
      state_q == S_READ:  st = ST_BUSY;
      state_q == S_WRITE: st = ST_BUSY;
      state_q == S_DONE:  st = ST_DONE;
      default:            st = ST_IDLE;
    endcase
  end

  assign wr_c    = state_q == S_WRITE;
  assign drive_a = wr_c ||
                   (state_q == S_READ && cnt_q < n_q);

  assign bus.ram_wr        = wr_c;
  assign bus.ram_a         = drive_a ? addr_c : '0;
  assign bus.ram_dout      = wr_c ? wbyte : 8'h00;
  assign bus.if_status     = owner_if_q ? st : ST_IDLE;
  assign bus.mem_status    = owner_if_q ? ST_IDLE : st;
  assign bus.if_data_o     = if_data_q;
  assign bus.data_from_mem = mem_data_q;

`ifdef MEMCTRL_FETCH_BUF_EN
  assign fb_hit = fb_valid_q && fb_tag_q == bus.if_addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_if_q <= 1'b0;
      cnt_q      <= '0;
      n_q        <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
`ifdef MEMCTRL_FETCH_BUF_EN
      fb_valid_q <= 1'b0;
      fb_tag_q   <= '0;
      fb_word_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          acc_q <= '0;
          if (mem_rd || mem_wr) begin
            owner_if_q <= 1'b0;
            base_q     <= bus.addr_to_mem;
            n_q        <= n_of(bus.quantity);
            wdata_q    <= bus.data_to_mem;
            state_q    <= mem_rd ? S_READ : S_WRITE;
`ifdef MEMCTRL_FETCH_BUF_EN
            if (mem_wr) fb_valid_q <= 1'b0;
`endif
          end else if (bus.if_req) begin
            owner_if_q <= 1'b1;
            base_q     <= bus.if_addr;
            n_q        <= 3'd4;
`ifdef MEMCTRL_FETCH_BUF_EN
            if (fb_hit) begin
              state_q   <= S_DONE;
              if_data_q <= fb_word_q;
            end else begin
              state_q <= S_READ;
            end
`else
            state_q <= S_READ;
`endif
          end
        end
        S_READ: begin
          acc_q <= acc_fill;
          if (cnt_q == n_q) begin
            state_q <= S_DONE;
            if (owner_if_q) begin
              if_data_q <= acc_fill;
`ifdef MEMCTRL_FETCH_BUF_EN
              fb_valid_q <= 1'b1;
              fb_tag_q   <= base_q;
              fb_word_q  <= acc_fill;
`endif
            end else begin
              mem_data_q <= acc_fill;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_WRITE: begin
          if (cnt_q == n_q - 3'd1) state_q <= S_DONE;
          else cnt_q <= cnt_q + 3'd1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
